// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe
// Simple dual-port RAM (one write port, one read port, one clock) with
// per-lane byte enables, a read latency of 0, 1 or 2 cycles with a valid
// strobe, a selectable same-address read-during-write policy and a clear
// engine that zeroes the whole array after reset or on request.
// The array is split into one memory per byte lane so every lane carries
// its own write enable and maps onto a plain RAM primitive.
module dual_port_ram_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            data_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en_i,
  input  logic                             write_en_i,
  input  logic [ADDR_WIDTH-1:0]            write_addr_i,
  input  logic                             read_en_i,
  input  logic [ADDR_WIDTH-1:0]            read_addr_i,
  input  logic                             clear_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             valid_o,
  output logic                             busy_o
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int MEM_SIZE  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_addr_reg;
  logic [ADDR_WIDTH-1:0]   clr_addr_next;
  logic                    busy_reg;
  logic                    clr_we;

  // Clear engine state, sweep address and the registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RESET_STATE;
      clr_addr_reg <= '0;
      busy_reg     <= (CLEAR_ON_RESET != 0);
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      busy_reg     <= (state_next == ST_CLEAR);
    end
  end

  // Next state: sweep every address once, ignoring clear_i while sweeping
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    clr_we        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear_i) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end
      end
      ST_CLEAR: begin
        clr_we        = 1'b1;
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        clr_addr_next = '0;
      end
    endcase
  end

  assign busy_o = busy_reg;

  // ---------------------------------------------------------------------
  // Access acceptance
  // ---------------------------------------------------------------------
  logic wr_accept;
  logic rd_accept;
  logic rd_hit;

  assign wr_accept = write_en_i & ~busy_reg;
  assign rd_accept = read_en_i  & ~busy_reg;
  assign rd_hit    = wr_accept & (write_addr_i == read_addr_i);

  // ---------------------------------------------------------------------
  // Shared write port: the clear engine owns it while busy
  // ---------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]  lane_we;

  // Select clear sweep or user write; nothing is written while in reset
  always_comb begin
    wr_addr = write_addr_i;
    wr_data = data_i;
    lane_we = '0;
    if (clr_we) begin
      wr_addr = clr_addr_reg;
      wr_data = '0;
      lane_we = '1;
    end else if (wr_accept) begin
      lane_we = byte_en_i;
    end
    if (!rst_n) begin
      lane_we = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Byte-lane memories
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_old;  // contents before the current edge
  logic [DATA_WIDTH-1:0] rd_new;  // contents after merging a colliding write

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [BYTE_WIDTH-1:0] mem [MEM_SIZE];

    // Lane write; contents are deliberately untouched by reset
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        mem[wr_addr] <= wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign rd_old[gi*BYTE_WIDTH +: BYTE_WIDTH] = mem[read_addr_i];
    assign rd_new[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      (rd_hit && byte_en_i[gi]) ? data_i[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                : mem[read_addr_i];
  end

  // Same-address policy for the registered read paths
  logic [DATA_WIDTH-1:0] rd_sel;
  assign rd_sel = (RDW_MODE == 0) ? rd_new : rd_old;

  // ---------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------
  if (READ_LATENCY == 0) begin : g_lat0
    // Combinational read: shows the array as it stands before the edge
    assign data_o  = rd_old;
    assign valid_o = rd_accept;
  end else begin : g_lat_reg
    logic [DATA_WIDTH-1:0] stage1_reg;
    logic                  valid1_reg;

    // First stage: capture only on accepted reads so data_o holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage1_reg <= '0;
        valid1_reg <= 1'b0;
      end else begin
        valid1_reg <= rd_accept;
        if (rd_accept) begin
          stage1_reg <= rd_sel;
        end
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      assign data_o  = stage1_reg;
      assign valid_o = valid1_reg;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] stage2_reg;
      logic                  valid2_reg;

      // Second stage: advances with the valid bit, independent of busy so an
      // in-flight read still completes when a clear starts behind it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage2_reg <= '0;
          valid2_reg <= 1'b0;
        end else begin
          valid2_reg <= valid1_reg;
          if (valid1_reg) begin
            stage2_reg <= stage1_reg;
          end
        end
      end

      assign data_o  = stage2_reg;
      assign valid_o = valid2_reg;
    end
  end

endmodule
